// File: rtl/register_file_param.sv
// Parametrised register file: two registered read ports, one write port,
// and a flag register with its own write port, conflict pulse and bypass.
module register_file_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int FLAG_W    = 7,
  parameter int FLAG_REG  = 3,
  parameter int ZERO_REG0 = 1,
  parameter int BYPASS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rd_valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd,
  input  logic              flag_we,
  input  logic [FLAG_W-1:0] flag_in,
  output logic [FLAG_W-1:0] flag_out,
  output logic              wr_conflict
);

  localparam int NREG = 2 ** ADDR_W;

  if (FLAG_W > DATA_W) begin : g_bad_flag_w
    $fatal(1, "register_file_param: FLAG_W > DATA_W");
  end
  if (FLAG_REG >= NREG) begin : g_bad_flag_reg
    $fatal(1, "register_file_param: FLAG_REG out of range");
  end

  localparam logic [ADDR_W-1:0] FREG = ADDR_W'(FLAG_REG);
  localparam bit Z0 = (ZERO_REG0 != 0);
  localparam bit BP = (BYPASS != 0);

  logic [DATA_W-1:0] regs [NREG];

  logic [DATA_W-1:0] flag_ext;
  logic              flag_ok;
  logic              gen_ok;
  logic              conflict;

  assign flag_ext = DATA_W'(flag_in);
  assign flag_ok  = flag_we && !(Z0 && FREG == '0);
  assign conflict = we && flag_we && (a3 == FREG);
  assign gen_ok   = we && !(Z0 && a3 == '0) && !conflict;
  assign flag_out = regs[FREG][FLAG_W-1:0];

  // Effective value seen by a read issued on this edge.
  function automatic logic [DATA_W-1:0] rdata(input logic [ADDR_W-1:0] a);
    if (Z0 && a == '0)
      return '0;
    if (BP && flag_ok && a == FREG)
      return flag_ext;
    if (BP && gen_ok && a == a3)
      return wd;
    return regs[a];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      rd1         <= '0;
      rd2         <= '0;
      rd_valid    <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      if (gen_ok)
        regs[a3] <= wd;
      if (flag_ok)
        regs[FREG] <= flag_ext;
      rd1         <= rd_en ? rdata(a1) : '0;
      rd2         <= rd_en ? rdata(a2) : '0;
      rd_valid    <= rd_en;
      wr_conflict <= conflict;
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench: default instance (R0 zero, bypass) and a
// second one with R0 writable and read-first behaviour.
module tb_register_file_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_en;
  logic [4:0] a1, a2, a3;
  logic [7:0] wd;
  logic       we;
  logic       flag_we;
  logic [6:0] flag_in;

  logic [7:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic       val_0, val_1, cf_0, cf_1;
  logic [6:0] fo_0, fo_1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  register_file_param u0 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .a1(a1), .a2(a2),
    .rd1(rd1_0), .rd2(rd2_0), .rd_valid(val_0),
    .we(we), .a3(a3), .wd(wd),
    .flag_we(flag_we), .flag_in(flag_in),
    .flag_out(fo_0), .wr_conflict(cf_0)
  );

  register_file_param #(.ZERO_REG0(0), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .a1(a1), .a2(a2),
    .rd1(rd1_1), .rd2(rd2_1), .rd_valid(val_1),
    .we(we), .a3(a3), .wd(wd),
    .flag_we(flag_we), .flag_in(flag_in),
    .flag_out(fo_1), .wr_conflict(cf_1)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; we = 1'b0; flag_we = 1'b0;
    a1 = '0; a2 = '0; a3 = '0; wd = '0; flag_in = '0;
    tick();
    rst = 1'b0;
    check("rst_rd1", 32'(rd1_0), 32'h0);
    check("rst_valid", 32'(val_0), 32'h0);
    check("rst_flag", 32'(fo_0), 32'h0);
    check("rst_conf", 32'(cf_0), 32'h0);

    // reset clears a written register
    we = 1'b1; a3 = 5'd7; wd = 8'hA5;
    tick();
    we = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_flag", 32'(fo_0), 32'h0);
    check("rst2_conf", 32'(cf_0), 32'h0);
    rd_en = 1'b1; a1 = 5'd7;
    tick();
    check("rst2_rd1", 32'(rd1_0), 32'h0);
    check("rst2_valid", 32'(val_0), 32'h1);

    // rst overrides rd_en
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_ovr_valid", 32'(val_0), 32'h0);
    rd_en = 1'b0;

    // write then read
    we = 1'b1; a3 = 5'd5; wd = 8'h3C;
    tick();
    we = 1'b0; rd_en = 1'b1; a1 = 5'd5; a2 = 5'd0;
    tick();
    check("wr_rd1", 32'(rd1_0), 32'h3C);
    check("wr_rd2", 32'(rd2_0), 32'h0);
    check("wr_valid", 32'(val_0), 32'h1);
    rd_en = 1'b0;
    tick();
    check("idle_rd1", 32'(rd1_0), 32'h0);
    check("idle_rd2", 32'(rd2_0), 32'h0);
    check("idle_valid", 32'(val_0), 32'h0);

    // R0 protection
    we = 1'b1; a3 = 5'd0; wd = 8'hFF;
    tick();
    we = 1'b0; rd_en = 1'b1; a1 = 5'd0;
    tick();
    check("r0_zero", 32'(rd1_0), 32'h0);
    check("r0_rw", 32'(rd1_1), 32'hFF);
    // same-cycle R0 write is never forwarded
    we = 1'b1; a3 = 5'd0; wd = 8'h5A;
    tick();
    we = 1'b0;
    check("r0_byp_zero", 32'(rd1_0), 32'h0);
    check("r0_rdfirst", 32'(rd1_1), 32'hFF);
    rd_en = 1'b0;

    // bypass vs read-first on R9
    we = 1'b1; a3 = 5'd9; wd = 8'h11;
    tick();
    wd = 8'h77; rd_en = 1'b1; a1 = 5'd9; a2 = 5'd9;
    tick();
    we = 1'b0;
    check("byp_rd1", 32'(rd1_0), 32'h77);
    check("byp_rd2", 32'(rd2_0), 32'h77);
    check("rf_rd1", 32'(rd1_1), 32'h11);
    check("rf_rd2", 32'(rd2_1), 32'h11);
    tick();
    check("rf_next", 32'(rd1_1), 32'h77);
    rd_en = 1'b0;

    // flag collision, read of R3 in the same cycle
    we = 1'b1; a3 = 5'd3; wd = 8'hEE;
    flag_we = 1'b1; flag_in = 7'h55;
    rd_en = 1'b1; a1 = 5'd3; a2 = 5'd5;
    tick();
    we = 1'b0; flag_we = 1'b0;
    check("col_flag", 32'(fo_0), 32'h55);
    check("col_conf", 32'(cf_0), 32'h1);
    check("col_conf_u1", 32'(cf_1), 32'h1);
    check("col_byp", 32'(rd1_0), 32'h55);
    check("col_rf", 32'(rd1_1), 32'h0);
    tick();
    check("col_rd3", 32'(rd1_0), 32'h55);
    check("col_rd3_u1", 32'(rd1_1), 32'h55);
    check("col_conf_off", 32'(cf_0), 32'h0);
    rd_en = 1'b0;

    // independent flag and general write
    flag_we = 1'b1; flag_in = 7'h2A;
    we = 1'b1; a3 = 5'd10; wd = 8'h99;
    tick();
    we = 1'b0; flag_we = 1'b0;
    check("ind_flag", 32'(fo_0), 32'h2A);
    check("ind_conf", 32'(cf_0), 32'h0);
    rd_en = 1'b1; a1 = 5'd10; a2 = 5'd3;
    tick();
    check("ind_r10", 32'(rd1_0), 32'h99);
    check("ind_r3", 32'(rd2_0), 32'h2A);
    rd_en = 1'b0;

    // general write to the flag register updates flag_out
    we = 1'b1; a3 = 5'd3; wd = 8'hC6;
    tick();
    we = 1'b0;
    check("gw_flag", 32'(fo_0), 32'h46);
    check("gw_conf", 32'(cf_0), 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised successor to the core register file: two registered read ports, one write port, and a dedicated flag register with its own write port.
- Sits between the decode/control unit and the ALU. Adds synchronous reset, optional hardwired-zero R0, write-first bypass, a flag conflict indicator, and a read-valid strobe.
- All state is updated on the rising edge of clk; there are no simulation delays in the RTL.

Parameters:
DATA_W, 8, register data width in bits
ADDR_W, 5, address width; the file holds 2**ADDR_W registers
FLAG_W, 7, flag input width; must be <= DATA_W
FLAG_REG, 3, index of the register that holds the flags
ZERO_REG0, 1, 1 = register 0 reads as 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write to an address being read is forwarded (write-first); 0 = the old value is returned (read-first)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
rd_en  in  1  read request, sampled at the clk edge
a1  in  ADDR_W  read address, port 1
a2  in  ADDR_W  read address, port 2
rd1  out  DATA_W  read data, port 1 (registered)
rd2  out  DATA_W  read data, port 2 (registered)
rd_valid  out  1  high for the cycle in which rd1/rd2 hold data from an accepted read
we  in  1  general write enable
a3  in  ADDR_W  write address
wd  in  DATA_W  write data (from ALU or memory)
flag_we  in  1  flag write enable
flag_in  in  FLAG_W  new flag values
flag_out  out  FLAG_W  current flags, equal to registers[FLAG_REG][FLAG_W-1:0]
wr_conflict  out  1  one-cycle pulse: the general write and the flag write collided on FLAG_REG

Behaviour:
- Reset (rst=1 at the edge):
  - every register is cleared to 0.
  - rd1, rd2, rd_valid, wr_conflict and flag_out go to 0.
  - rst overrides we, flag_we and rd_en in the same cycle.
  - Reset is accepted mid-operation; no pending state survives it.
- General write:
  - when we=1, registers[a3] <= wd at the edge.
  - If ZERO_REG0=1 and a3=0, the write is dropped.
- Flag write:
  - when flag_we=1, registers[FLAG_REG] <= flag_in zero-extended to DATA_W.
  - The flag write happens only on flag_we. Unlike the previous generation, a general write does not update the flags as a side effect.
- Collision:
  - condition: we=1, flag_we=1 and a3=FLAG_REG in the same cycle.
  - the flag write wins and wd is discarded.
  - wr_conflict=1 in the following cycle, otherwise 0.
  - we to a different address alongside flag_we: both writes complete and there is no conflict.
- Read:
  - one-cycle latency. When rd_en=1 at edge N, rd1/rd2 hold the data from cycle N+1 onward and rd_valid=1 for that cycle.
  - When rd_en=0 at an edge, rd1=rd2=0 and rd_valid=0 in the following cycle.
  - Reading address 0 with ZERO_REG0=1 always returns 0.
- Bypass, same edge as the read:
  - BYPASS=1: for each port independently, if a write targets that port's address, the read returns the value written in that cycle. That value is the effective one: flag_in zero-extended when the flag write wins; never a dropped R0 write.
  - BYPASS=0: the pre-write contents are returned.
  - a1=a2 returns identical data on both ports.
- flag_out:
  - comes directly from register storage, so it updates the cycle after any write to FLAG_REG, including a general write with flag_we=0.
- Address width:
  - only ADDR_W bits are used; there is no out-of-range condition.
- Parameter check:
  - simulation halts with an error if FLAG_W > DATA_W or if FLAG_REG >= 2**ADDR_W.

Test Plan:
- Reset: write 8'hA5 to R7, then rst=1 for one cycle, then read R7 -> rd1=0, rd_valid=1; before that read, flag_out=0 and wr_conflict=0.
- Write then read: we, a3=5, wd=8'h3C. Next cycle rd_en, a1=5, a2=0 -> one cycle later rd1=8'h3C, rd2=0, rd_valid=1. Then rd_en=0 -> rd1=rd2=0, rd_valid=0.
- R0 protection: we, a3=0, wd=8'hFF, then read a1=0 -> rd1=0. Repeat with ZERO_REG0=0 -> rd1=8'hFF.
- Bypass, with R9 preloaded to 8'h11: in the same cycle we, a3=9, wd=8'h77 and rd_en, a1=9.
  - BYPASS=1 -> rd1=8'h77.
  - BYPASS=0 -> rd1=8'h11; a read in the following cycle returns 8'h77.
- Flag collision: we, a3=3, wd=8'hEE, flag_we, flag_in=7'h55 in the same cycle.
  - next cycle: flag_out=7'h55, wr_conflict=1, and a read of R3 returns 8'h55.
  - the cycle after: wr_conflict=0.
- Independent flags: flag_we, flag_in=7'h2A together with we, a3=10, wd=8'h99 -> R10=8'h99, flag_out=7'h2A, wr_conflict=0.
